// File: rtl/systolic_seq_ctrl.sv
// Purpose: sequences one N x N systolic matmul: clear array, feed K skewed operand steps, drain, unload C row by row.
// Latency: start sampled in cycle 0 -> first res_valid in cycle K+2N+2; done pulses in the cycle the last row is accepted.
// Backpressure: res_valid/res_row/res_data hold while res_ready is low; the array sees zero edges, so C stays stable.
module systolic_seq_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int N         = 4,
    parameter int K         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [$clog2(K)-1:0]         rd_addr,
    input  logic [N*DATA_SIZE-1:0]       a_col,
    input  logic [N*DATA_SIZE-1:0]       b_row,
    output logic                         arr_clear,
    output logic [N*DATA_SIZE-1:0]       arr_a,
    output logic [N*DATA_SIZE-1:0]       arr_b,
    input  logic [N*N*2*DATA_SIZE-1:0]   arr_c,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(N)-1:0]         res_row,
    output logic [N*2*DATA_SIZE-1:0]     res_data
);

    localparam int AW    = $clog2(K);
    localparam int RW    = $clog2(N);
    localparam int CW    = $clog2(2 * N);
    localparam int ROW_W = N * 2 * DATA_SIZE;

    localparam logic [AW-1:0] LAST_K     = AW'(K - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic            rd_vld_q;
    logic            skew_clr;
    logic [N*DATA_SIZE-1:0] a_in;
    logic [N*DATA_SIZE-1:0] b_in;

    assign busy      = (state != S_IDLE);
    assign skew_clr  = (state == S_CLEAR);
    assign arr_clear = reset | skew_clr;
    // Combinational so the pulse lands in the very cycle the final row handshake completes.
    assign done      = res_valid & res_ready & (res_row == LAST_ROW);

    // Main sequencer: phase transitions, read address walk, result row handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state   <= S_FEED;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                end
                S_FEED: begin
                    if (rd_addr == LAST_K) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                        drain_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // 2N cycles lets the last skewed operand pair reach PE(N-1,N-1) and accumulate.
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_UNLOAD;
                        res_valid <= 1'b1;
                        res_row   <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (res_ready) begin
                        if (res_row == LAST_ROW) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b0;
                            res_row   <= '0;
                        end else begin
                            res_row <= res_row + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand read data is valid one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (reset || skew_clr) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
        end
    end

    // Zero the chain input whenever no fresh read data is present; PEs accumulate every cycle.
    assign a_in = rd_vld_q ? a_col : '0;
    assign b_in = rd_vld_q ? b_row : '0;

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign arr_a[0 +: DATA_SIZE] = a_in[0 +: DATA_SIZE];
            assign arr_b[0 +: DATA_SIZE] = b_in[0 +: DATA_SIZE];
        end else begin : g_pipe
            logic [DATA_SIZE-1:0] a_pipe [i];
            logic [DATA_SIZE-1:0] b_pipe [i];

            // Row/column i is delayed i cycles so A and B wavefronts meet on the diagonals.
            always_ff @(posedge clk) begin
                if (reset || skew_clr) begin
                    for (int s = 0; s < i; s++) begin
                        a_pipe[s] <= '0;
                        b_pipe[s] <= '0;
                    end
                end else begin
                    a_pipe[0] <= a_in[i*DATA_SIZE +: DATA_SIZE];
                    b_pipe[0] <= b_in[i*DATA_SIZE +: DATA_SIZE];
                    for (int s = 1; s < i; s++) begin
                        a_pipe[s] <= a_pipe[s-1];
                        b_pipe[s] <= b_pipe[s-1];
                    end
                end
            end

            assign arr_a[i*DATA_SIZE +: DATA_SIZE] = a_pipe[i-1];
            assign arr_b[i*DATA_SIZE +: DATA_SIZE] = b_pipe[i-1];
        end
    end

    // Select the accumulator row currently offered to the consumer.
    always_comb begin
        res_data = '0;
        for (int r = 0; r < N; r++) begin
            if (res_row == RW'(r)) begin
                res_data = arr_c[r*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic start_s [2];
    logic ready_s [2];

    int opa [2][4][4];
    int opb [2][4][4];
    int got_row [2][4][4];
    int first_vld [2];
    int done_cyc [2];
    int feed_cnt [2];
    int acc_cnt [2];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // C[i][j] from the matrix definition, wrapped to 16 bits.
    function automatic int exp_c(input int g, input int i, input int j, input int kk);
        int s;
        s = 0;
        for (int k = 0; k < kk; k++) s += opa[g][i][k] * opb[g][k][j];
        return s & 32'hFFFF;
    endfunction

    // u[0]: N=K=2, u[1]: N=K=4.
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int NN = (g == 0) ? 2 : 4;
        localparam int KK = NN;
        localparam int AW = $clog2(KK);
        localparam int RW = $clog2(NN);

        logic               busy, done, rd_en, arr_clear, res_valid;
        logic [AW-1:0]      rd_addr;
        logic [RW-1:0]      res_row;
        logic [NN*8-1:0]    a_col, b_row, arr_a, arr_b;
        logic [NN*NN*16-1:0] arr_c;
        logic [NN*16-1:0]   res_data;
        logic [15:0]        pc [NN][NN];
        logic [7:0]         pa [NN][NN];
        logic [7:0]         pb [NN][NN];

        systolic_seq_ctrl #(.DATA_SIZE(8), .N(NN), .K(KK)) dut (
            .clk(clk), .reset(reset), .start(start_s[g]), .busy(busy), .done(done),
            .rd_en(rd_en), .rd_addr(rd_addr), .a_col(a_col), .b_row(b_row),
            .arr_clear(arr_clear), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
            .res_valid(res_valid), .res_ready(ready_s[g]), .res_row(res_row), .res_data(res_data)
        );

        // Operand buffers: registered 1-cycle read; data left stale when not reading.
        always @(posedge clk) begin
            if (rd_en) begin
                for (int i = 0; i < NN; i++) begin
                    a_col[i*8 +: 8] <= 8'(opa[g][i][int'(rd_addr)]);
                    b_row[i*8 +: 8] <= 8'(opb[g][int'(rd_addr)][i]);
                end
            end
        end

        // MAC PE grid: accumulate, forward A east and B south.
        always @(posedge clk) begin
            logic [7:0] ia, ib;
            for (int i = 0; i < NN; i++) begin
                for (int j = 0; j < NN; j++) begin
                    ia = (j == 0) ? arr_a[i*8 +: 8] : pa[i][j-1];
                    ib = (i == 0) ? arr_b[j*8 +: 8] : pb[i-1][j];
                    if (arr_clear) begin
                        pc[i][j] <= '0;
                        pa[i][j] <= '0;
                        pb[i][j] <= '0;
                    end else begin
                        pc[i][j] <= pc[i][j] + 16'(ia) * 16'(ib);
                        pa[i][j] <= ia;
                        pb[i][j] <= ib;
                    end
                end
            end
        end

        always_comb begin
            arr_c = '0;
            for (int i = 0; i < NN; i++)
                for (int j = 0; j < NN; j++)
                    arr_c[(i*NN+j)*16 +: 16] = pc[i][j];
        end

        // Reference timeline: cycle t after start is accepted decides every output.
        bit mb = 1'b0;
        bit post_rst = 1'b0;
        int t0 = 0;
        int mrow = 0;
        always @(negedge clk) begin
            int t;
            int k;
            bit unl;
            bit feed;
            t    = cyc - t0;
            unl  = mb && (t >= KK + 2*NN + 2);
            feed = mb && (t >= 2) && (t <= KK + 1);
            chk("busy", busy, mb);
            chk("arr_clear", arr_clear, reset | (mb && t == 1));
            chk("rd_en", rd_en, feed);
            if (feed) chk("rd_addr", rd_addr, t - 2);
            if (!mb && post_rst) begin
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_res_row", res_row, 0);
            end
            for (int i = 0; i < NN; i++) begin
                k = t - 3 - i;
                chk("arr_a", arr_a[i*8 +: 8], (mb && k >= 0 && k < KK) ? opa[g][i][k] : 0);
                chk("arr_b", arr_b[i*8 +: 8], (mb && k >= 0 && k < KK) ? opb[g][k][i] : 0);
            end
            chk("res_valid", res_valid, unl);
            if (unl) begin
                chk("res_row", res_row, mrow);
                for (int j = 0; j < NN; j++)
                    chk("res_data", res_data[j*16 +: 16], exp_c(g, mrow, j, KK));
            end
            chk("done", done, unl && ready_s[g] && mrow == NN - 1);

            if (res_valid && first_vld[g] < 0) first_vld[g] = cyc;
            if (done && done_cyc[g] < 0) done_cyc[g] = cyc;
            if (rd_en) feed_cnt[g]++;
            if (res_valid && ready_s[g]) begin
                acc_cnt[g]++;
                for (int j = 0; j < NN; j++) got_row[g][int'(res_row)][j] = int'(res_data[j*16 +: 16]);
            end

            if (reset) begin
                mb = 1'b0;
                mrow = 0;
                post_rst = 1'b1;
            end else if (!mb) begin
                if (start_s[g]) begin
                    mb = 1'b1;
                    t0 = cyc;
                    mrow = 0;
                    post_rst = 1'b0;
                end
            end else if (unl && ready_s[g]) begin
                mrow++;
                if (mrow == NN) mb = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int g, output int st);
        first_vld[g] = -1;
        done_cyc[g]  = -1;
        feed_cnt[g]  = 0;
        acc_cnt[g]   = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) got_row[g][i][j] = -1;
        start_s[g] = 1'b1;
        st = cyc;
        tick(1);
        start_s[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input string nm);
        int n;
        n = 0;
        while (done_cyc[g] < 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk({nm, "_finished"}, done_cyc[g] >= 0, 1);
        tick(2);
    endtask

    task automatic set_ops2(input int a00, input int a01, input int a10, input int a11,
                            input int b00, input int b01, input int b10, input int b11);
        opa[0][0][0] = a00; opa[0][0][1] = a01; opa[0][1][0] = a10; opa[0][1][1] = a11;
        opb[0][0][0] = b00; opb[0][0][1] = b01; opb[0][1][0] = b10; opb[0][1][1] = b11;
    endtask

    task automatic chk_rows2(input string nm, input int c00, input int c01, input int c10, input int c11);
        chk({nm, "_c00"}, got_row[0][0][0], c00);
        chk({nm, "_c01"}, got_row[0][0][1], c01);
        chk({nm, "_c10"}, got_row[0][1][0], c10);
        chk({nm, "_c11"}, got_row[0][1][1], c11);
    endtask

    initial begin
        int st;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0;
            ready_s[g] = 1'b1;
            first_vld[g] = -1;
            done_cyc[g] = -1;
            feed_cnt[g] = 0;
            acc_cnt[g] = 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    opa[g][i][j] = 0;
                    opb[g][i][j] = 0;
                    got_row[g][i][j] = -1;
                end
        end
        tick(3);
        reset = 1'b0;
        tick(2);

        // Basic multiply with continuous acceptance.
        set_ops2(1, 2, 3, 4, 5, 6, 7, 8);
        launch(0, st);
        wait_done(0, "t1");
        chk("t1_first_valid", first_vld[0] - st, 8);
        chk("t1_done_cycle", done_cyc[0] - st, 9);
        chk("t1_rows", acc_cnt[0], 2);
        chk_rows2("t1", 19, 22, 43, 50);

        // Wraparound at full-scale operands.
        set_ops2(255, 255, 255, 255, 255, 255, 255, 255);
        launch(0, st);
        wait_done(0, "t2");
        chk_rows2("t2", 64514, 64514, 64514, 64514);

        // Consumer stalls for 5 UNLOAD cycles (cycles 8..12).
        set_ops2(2, 0, 1, 3, 4, 1, 2, 5);
        ready_s[0] = 1'b0;
        launch(0, st);
        tick(12);
        ready_s[0] = 1'b1;
        wait_done(0, "t3");
        chk("t3_first_valid", first_vld[0] - st, 8);
        chk("t3_done_cycle", done_cyc[0] - st, 14);
        chk_rows2("t3", 8, 2, 10, 16);

        // Extra start pulses in FEED and DRAIN are ignored.
        set_ops2(1, 2, 3, 4, 5, 6, 7, 8);
        launch(0, st);
        tick(1);
        start_s[0] = 1'b1;
        tick(1);
        start_s[0] = 1'b0;
        tick(3);
        start_s[0] = 1'b1;
        tick(1);
        start_s[0] = 1'b0;
        wait_done(0, "t4");
        chk("t4_done_cycle", done_cyc[0] - st, 9);
        chk("t4_rows", acc_cnt[0], 2);
        tick(6);
        chk("t4_feed_steps", feed_cnt[0], 2);
        chk_rows2("t4", 19, 22, 43, 50);

        // Reset mid-FEED, then a clean run.
        set_ops2(255, 255, 255, 255, 255, 255, 255, 255);
        launch(0, st);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("t5_aborted_rows", acc_cnt[0], 0);
        set_ops2(1, 2, 3, 4, 5, 6, 7, 8);
        launch(0, st);
        wait_done(0, "t5");
        chk("t5_done_cycle", done_cyc[0] - st, 9);
        chk_rows2("t5", 19, 22, 43, 50);

        // 4x4: identity times 1..16 gives B back.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                opa[1][i][j] = (i == j) ? 1 : 0;
                opb[1][i][j] = i * 4 + j + 1;
            end
        launch(1, st);
        wait_done(1, "t6");
        chk("t6_first_valid", first_vld[1] - st, 14);
        chk("t6_done_cycle", done_cyc[1] - st, 17);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk("t6_c", got_row[1][i][j], i * 4 + j + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
